evr_trigger_decoder: RTL and testbench
======================================

# evr_trigger_decoder

Maps incoming event-receiver event codes to per-output trigger strobes through a software-loaded lookup table. Detects the heartbeat event and supervises it with a watchdog. Sits directly upstream of the per-pin output drivers: each `triggerStrobe` bit feeds one driver's trigger input, and `evrHBstrobe` feeds all drivers' heartbeat input. Runs entirely in the EVR clock domain; CSR writes arrive already synchronised to `evrClk`.

## Interface
Parameters:
- `NUM_TRIGGERS`, 8: number of trigger outputs (1–32).
- `HEARTBEAT_CODE`, 8'h7A: event code treated as heartbeat.
- `HB_TIMEOUT_CYCLES`, 125000000: cycles without a heartbeat before `hbMissing` is set; must be ≥2.
- `HB_COUNT_WIDTH`, 28: watchdog counter width; must hold `HB_TIMEOUT_CYCLES`.

Ports:
- `evrClk`  in  1  EVR clock; the only clock.
- `evrRst_n`  in  1  reset, asynchronous, active-low.
- `evrCode`  in  8  received event code.
- `evrCodeValid`  in  1  `evrCode` is meaningful this cycle.
- `cfgWrite`  in  1  one-cycle table write strobe.
- `cfgAddress`  in  8  table address, which is the event code.
- `cfgData`  in  `NUM_TRIGGERS`  trigger mask to store.
- `cfgReady`  out  1  table initialised; writes accepted.
- `triggerStrobe`  out  `NUM_TRIGGERS`  one-cycle trigger pulses.
- `evrHBstrobe`  out  1  one-cycle heartbeat pulse.
- `hbMissing`  out  1  watchdog expired; sticky until the next heartbeat.

## Operation
- States: `S_INIT` and `S_RUN`.
- Reset entry:
  - State goes to `S_INIT`; all outputs go to 0.
  - `S_INIT` writes zero to table entries 0..255, one per cycle, using an internal address counter.
  - The FSM moves to `S_RUN` after entry 255 is written.
- In `S_INIT`, `cfgWrite` is ignored and code lookups produce no strobes. The heartbeat is still detected.
- `S_RUN`:
  - Stage 1 registers `evrCodeValid` and `evrCode` and reads the table. The read is read-first.
  - Stage 2 registers `triggerStrobe` as the table word AND valid.
- Event code 0x00 is null: it never produces strobes, whatever its table entry holds.
- Heartbeat: `evrHBstrobe` pulses when a valid code equals `HEARTBEAT_CODE`, aligned with the stage-2 strobes. The table entry for the heartbeat code still applies.
- Watchdog:
  - The counter resets to 0 on a heartbeat.
  - Otherwise it increments and saturates at `HB_TIMEOUT_CYCLES`.
  - `hbMissing` is set when the count reaches `HB_TIMEOUT_CYCLES`.
  - `hbMissing` clears in the cycle `evrHBstrobe` asserts.
- Collision: when `cfgWrite` and a lookup hit the same address in the same cycle, the lookup returns the old mask and the new mask applies from the next lookup.
- Back-to-back valid codes on consecutive cycles each produce their own strobe cycle; there is no merging and no stall.

## Timing
- Latency: valid code on cycle N gives `triggerStrobe`/`evrHBstrobe` on cycle N+2, high for exactly one cycle.
- Table write:
  - Takes one cycle.
  - A code presented on the cycle after the write sees the new mask.
- `cfgReady` is 0 from reset through 256 init cycles and rises on the first `S_RUN` cycle.
- Reset asserted mid-operation:
  - Immediately clears outputs, pipeline, watchdog and `hbMissing`.
  - Restarts `S_INIT`; table contents are cleared again.

## Configuration
- `EVR_TRIGGER_FORCE_EN`
  - Defined: adds input `forceTrigger [NUM_TRIGGERS-1:0]`. A pulse ORs into `triggerStrobe` with the same 2-cycle latency, is allowed in `S_INIT`, and is not masked by code 0x00.
  - Undefined: the port is absent and behaviour is exactly as above.

## Structure
- Shared package `evr_pkg`:
  - `EVR_CODE_WIDTH` = 8.
  - `EVR_CODE_NULL` = 8'h00.
  - `EVR_CODE_HEARTBEAT_DEFAULT` = 8'h7A.
  - Typedef `evr_code_t`.
- One natural sub-module, `evr_hb_watchdog`: the saturating counter and `hbMissing` flag, reusable by other heartbeat consumers.
- Table: 256×`NUM_TRIGGERS` single-clock RAM, inferred in the top level.

## Test plan
- Reset released; hold `evrCode`=0x01 valid with table unwritten → `cfgReady` rises after 256 cycles; no strobes throughout.
- Write mask 0x05 at address 0x10; present code 0x10 for one cycle on cycle N → `triggerStrobe`=0x05 on N+2 only.
- Write mask 0xFF at 0x00; present code 0x00 → no strobe. With `EVR_TRIGGER_FORCE_EN`, `forceTrigger`=0x80 → strobe 0x80 two cycles later.
- Write 0x01 then 0x02 to 0x20 while code 0x20 arrives in the same cycle as the second write → strobe 0x01; a repeat of 0x20 gives 0x02.
- `HB_TIMEOUT_CYCLES`=100:
  - Send code 0x7A → `evrHBstrobe` at +2.
  - With no heartbeat for 100 cycles, `hbMissing`=1.
  - The next 0x7A clears `hbMissing` on its strobe cycle.
- Assert `evrRst_n` low while a strobe is in the pipeline → outputs 0 immediately; after release, `cfgReady`=0 for 256 cycles and the earlier mask reads zero.

Source files
------------

// File: rtl/evr_pkg.sv
// Shared event-receiver definitions: code width, reserved codes and decoder FSM states.
package evr_pkg;

  localparam int EVR_CODE_WIDTH  = 8;
  localparam int EVR_TABLE_DEPTH = 1 << EVR_CODE_WIDTH;

  typedef logic [EVR_CODE_WIDTH-1:0] evr_code_t;

  localparam evr_code_t EVR_CODE_NULL              = 8'h00;
  localparam evr_code_t EVR_CODE_HEARTBEAT_DEFAULT = 8'h7A;

  typedef enum logic {
    S_INIT,
    S_RUN
  } dec_state_t;

endpackage

// File: rtl/evr_trigger_decoder_if.sv
// Event/config/trigger bundle between the EVR front end and the trigger decoder.
// forceTrigger exists only when EVR_TRIGGER_FORCE_EN is defined.
interface evr_trigger_decoder_if
  import evr_pkg::*;
#(
  parameter int NUM_TRIGGERS = 8
);
  evr_code_t               evrCode;
  logic                    evrCodeValid;
  logic                    cfgWrite;
  evr_code_t               cfgAddress;
  logic [NUM_TRIGGERS-1:0] cfgData;
  logic                    cfgReady;
  logic [NUM_TRIGGERS-1:0] triggerStrobe;
  logic                    evrHBstrobe;
  logic                    hbMissing;
`ifdef EVR_TRIGGER_FORCE_EN
  logic [NUM_TRIGGERS-1:0] forceTrigger;

  modport master (
    output evrCode, evrCodeValid, cfgWrite, cfgAddress, cfgData, forceTrigger,
    input  cfgReady, triggerStrobe, evrHBstrobe, hbMissing
  );
  modport slave (
    input  evrCode, evrCodeValid, cfgWrite, cfgAddress, cfgData, forceTrigger,
    output cfgReady, triggerStrobe, evrHBstrobe, hbMissing
  );
`else
  modport master (
    output evrCode, evrCodeValid, cfgWrite, cfgAddress, cfgData,
    input  cfgReady, triggerStrobe, evrHBstrobe, hbMissing
  );
  modport slave (
    input  evrCode, evrCodeValid, cfgWrite, cfgAddress, cfgData,
    output cfgReady, triggerStrobe, evrHBstrobe, hbMissing
  );
`endif
endinterface

// File: rtl/evr_hb_watchdog.sv
// Heartbeat watchdog: saturating cycle counter cleared by each heartbeat; missing
// flag is raised when the count reaches TIMEOUT_CYCLES and held until the next heartbeat.
module evr_hb_watchdog #(
  parameter int TIMEOUT_CYCLES = 125000000,
  parameter int COUNT_WIDTH    = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hb_i,
  output logic missing_o
);

  localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   missing_q, missing_d;

  always_comb begin
    cnt_d     = cnt_q;
    missing_d = missing_q;
    if (hb_i) begin
      cnt_d     = '0;
      missing_d = 1'b0;
    end else begin
      if (cnt_q != LIMIT) cnt_d = cnt_q + COUNT_WIDTH'(1);
      if (cnt_d == LIMIT) missing_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      missing_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      missing_q <= missing_d;
    end
  end

  assign missing_o = missing_q;

endmodule

// File: rtl/evr_trigger_decoder.sv
// Event-code to trigger-strobe decoder: 256-entry mask table, 2-stage lookup, heartbeat watchdog.
// Optional EVR_TRIGGER_FORCE_EN adds a forceTrigger input ORed into the strobes.
module evr_trigger_decoder
  import evr_pkg::*;
#(
  parameter int        NUM_TRIGGERS      = 8,
  parameter evr_code_t HEARTBEAT_CODE    = EVR_CODE_HEARTBEAT_DEFAULT,
  parameter int        HB_TIMEOUT_CYCLES = 125000000,
  parameter int        HB_COUNT_WIDTH    = 28
) (
  input logic                   evrClk,
  input logic                   evrRst_n,
  evr_trigger_decoder_if.slave  bus
);

  typedef logic [NUM_TRIGGERS-1:0] mask_t;

  mask_t      table_mem [EVR_TABLE_DEPTH];
  dec_state_t state_q, state_d;
  evr_code_t  init_addr_q, init_addr_d;
  logic       tbl_we;
  evr_code_t  tbl_waddr;
  mask_t      tbl_wdata;
  mask_t      tbl_rd_p1;
  logic       vld_p1_q, vld_p1_d;
  logic       hb_p1_q, hb_p1_d;
  mask_t      force_p1_q, force_p1_d;
  mask_t      strobe_p2_q, strobe_p2_d;
  logic       hb_p2_q, hb_p2_d;
  logic       hb_missing;

  // Table sequencing: INIT sweeps every entry to zero before software may write.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    tbl_we      = 1'b0;
    tbl_waddr   = bus.cfgAddress;
    tbl_wdata   = bus.cfgData;
    case (state_q)
      S_INIT: begin
        tbl_we      = 1'b1;
        tbl_waddr   = init_addr_q;
        tbl_wdata   = '0;
        init_addr_d = init_addr_q + evr_code_t'(1);
        if (init_addr_q == '1) state_d = S_RUN;
      end
      S_RUN:   tbl_we = bus.cfgWrite;
      default: state_d = S_INIT;
    endcase
  end

  // Stage 1: qualify the incoming code; the table read happens alongside.
  always_comb begin
    vld_p1_d = bus.evrCodeValid && (state_q == S_RUN) && (bus.evrCode != EVR_CODE_NULL);
    hb_p1_d  = bus.evrCodeValid && (bus.evrCode == HEARTBEAT_CODE);
`ifdef EVR_TRIGGER_FORCE_EN
    force_p1_d = bus.forceTrigger;
`else
    force_p1_d = '0;
`endif
  end

  // Stage 2: gate the looked-up mask.
  always_comb begin
    strobe_p2_d = (tbl_rd_p1 & {NUM_TRIGGERS{vld_p1_q}}) | force_p1_q;
    hb_p2_d     = hb_p1_q;
  end

  // Read-first RAM: a same-address write in the lookup cycle is not visible until the next read.
  always_ff @(posedge evrClk) begin
    if (tbl_we) table_mem[tbl_waddr] <= tbl_wdata;
    tbl_rd_p1 <= table_mem[bus.evrCode];
  end

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      vld_p1_q    <= 1'b0;
      hb_p1_q     <= 1'b0;
      force_p1_q  <= '0;
      strobe_p2_q <= '0;
      hb_p2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      vld_p1_q    <= vld_p1_d;
      hb_p1_q     <= hb_p1_d;
      force_p1_q  <= force_p1_d;
      strobe_p2_q <= strobe_p2_d;
      hb_p2_q     <= hb_p2_d;
    end
  end

  // Fed from stage 1 so the flag drops in the same cycle evrHBstrobe rises.
  evr_hb_watchdog #(
    .TIMEOUT_CYCLES (HB_TIMEOUT_CYCLES),
    .COUNT_WIDTH    (HB_COUNT_WIDTH)
  ) u_hb_watchdog (
    .clk       (evrClk),
    .rst_n     (evrRst_n),
    .hb_i      (hb_p1_q),
    .missing_o (hb_missing)
  );

  assign bus.cfgReady      = (state_q == S_RUN);
  assign bus.triggerStrobe = strobe_p2_q;
  assign bus.evrHBstrobe   = hb_p2_q;
  assign bus.hbMissing     = hb_missing;

endmodule

// File: tb/tb_evr_trigger_decoder.sv
// Directed bench for evr_trigger_decoder with a strobe scoreboard and a reference mask table.
module tb_evr_trigger_decoder;
  import evr_pkg::*;

  localparam int NT = 8;
  localparam int TO = 100;

  typedef struct packed {
    logic [NT-1:0] strobe;
    logic          hb;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  evr_trigger_decoder_if #(.NUM_TRIGGERS(NT)) bus ();

  evr_trigger_decoder #(
    .NUM_TRIGGERS      (NT),
    .HEARTBEAT_CODE    (8'h7A),
    .HB_TIMEOUT_CYCLES (TO),
    .HB_COUNT_WIDTH    (28)
  ) dut (
    .evrClk   (clk),
    .evrRst_n (rst_n),
    .bus      (bus)
  );

  exp_t          sb[$];
  logic [NT-1:0] model_tbl [256];
  int            checks   = 0;
  int            failures = 0;
  int            rel      = 0;
  int            cyc      = 0;
  int            hb_cyc   = -1000;
  bit            wd_armed = 1'b0;
`ifdef EVR_TRIGGER_FORCE_EN
  logic [NT-1:0] frc_v = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_trigger_strobe", 32'(bus.triggerStrobe), 32'h0);
    chk("rst_hb_strobe", 32'(bus.evrHBstrobe), 32'h0);
    chk("rst_hb_missing", 32'(bus.hbMissing), 32'h0);
    chk("rst_cfg_ready", 32'(bus.cfgReady), 32'h0);
    sb.delete();
    for (int i = 0; i < 256; i++) model_tbl[i] = '0;
    wd_armed = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel   = 0;
  endtask

  task automatic step(input logic v, input logic [7:0] code, input logic w,
                      input logic [7:0] addr, input logic [NT-1:0] data);
    exp_t e;
    exp_t o;
    bit   run;
    @(posedge clk);
    rel++;
    cyc++;
    #1;
    chk("cfg_ready", 32'(bus.cfgReady), 32'(rel >= 256));
    if (sb.size() >= 2) begin
      o = sb.pop_front();
      chk("trigger_strobe", 32'(bus.triggerStrobe), 32'(o.strobe));
      chk("hb_strobe", 32'(bus.evrHBstrobe), 32'(o.hb));
      if (o.hb) begin
        chk("hb_missing_clear", 32'(bus.hbMissing), 32'h0);
        hb_cyc   = cyc;
        wd_armed = 1'b1;
      end
    end else begin
      chk("strobe_fill", 32'(bus.triggerStrobe), 32'h0);
    end
    if (wd_armed && cyc == hb_cyc + TO - 1) chk("hb_missing_early", 32'(bus.hbMissing), 32'h0);
    if (wd_armed && cyc == hb_cyc + TO) begin
      chk("hb_missing_set", 32'(bus.hbMissing), 32'h1);
      wd_armed = 1'b0;
    end
    bus.evrCodeValid = v;
    bus.evrCode      = code;
    bus.cfgWrite     = w;
    bus.cfgAddress   = addr;
    bus.cfgData      = data;
    run      = (rel >= 256);
    e.hb     = v && (code == 8'h7A);
    e.strobe = (run && v && code != 8'h00) ? model_tbl[code] : '0;
`ifdef EVR_TRIGGER_FORCE_EN
    bus.forceTrigger = frc_v;
    e.strobe = e.strobe | frc_v;
`endif
    sb.push_back(e);
    if (run && w) model_tbl[addr] = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, '0);
  endtask

  initial begin
    bus.evrCodeValid = 1'b0;
    bus.evrCode      = '0;
    bus.cfgWrite     = 1'b0;
    bus.cfgAddress   = '0;
    bus.cfgData      = '0;
`ifdef EVR_TRIGGER_FORCE_EN
    bus.forceTrigger = '0;
`endif
    #1;
    do_reset();

    // Init sweep with a valid code held: no strobes, cfgReady after 256 cycles.
    for (int i = 0; i < 256; i++) step(1'b1, 8'h01, 1'b0, 8'h00, '0);
    idle(3);

    // Single lookup, then null code with a populated entry.
    step(1'b0, 8'h00, 1'b1, 8'h10, 8'h05);
    step(1'b1, 8'h10, 1'b0, 8'h00, '0);
    idle(3);
    step(1'b0, 8'h00, 1'b1, 8'h00, 8'hFF);
    step(1'b1, 8'h00, 1'b0, 8'h00, '0);
    idle(3);
`ifdef EVR_TRIGGER_FORCE_EN
    frc_v = 8'h80;
    step(1'b1, 8'h00, 1'b0, 8'h00, '0);
    frc_v = '0;
    idle(3);
`endif

    // Write/lookup collision, then back-to-back codes.
    step(1'b0, 8'h00, 1'b1, 8'h20, 8'h01);
    step(1'b1, 8'h20, 1'b1, 8'h20, 8'h02);
    step(1'b1, 8'h20, 1'b0, 8'h00, '0);
    step(1'b1, 8'h10, 1'b0, 8'h00, '0);
    step(1'b1, 8'h20, 1'b0, 8'h00, '0);
    step(1'b1, 8'h10, 1'b0, 8'h00, '0);
    idle(3);

    // Heartbeat strobe, watchdog expiry, then clearing on the next heartbeat.
    step(1'b0, 8'h00, 1'b1, 8'h7A, 8'h40);
    step(1'b1, 8'h7A, 1'b0, 8'h00, '0);
    idle(TO + 5);
    step(1'b1, 8'h7A, 1'b0, 8'h00, '0);
    idle(4);

    // Reset with a strobe on the output; table must come back cleared.
    step(1'b1, 8'h10, 1'b0, 8'h00, '0);
    idle(2);
    #1;
    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, 8'h10, (i == 5), 8'h10, 8'h33);
    step(1'b1, 8'h10, 1'b0, 8'h00, '0);
    step(1'b1, 8'h20, 1'b0, 8'h00, '0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
